// File: rtl/l1_refill_controller_pkg.sv
// Shared types for the L1 refill path: block positions, block payloads and refill FSM states.
package l1_refill_controller_pkg;

  localparam int COORD_W = 8;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } BlockPos;

  typedef logic [15:0] BlockType;

  localparam BlockType BLOCK_AIR   = '0;
  localparam coord_t   CHUNK_WIDTH = 8'sd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FILL  = 2'd3
  } RefillState;

endpackage

// File: rtl/l1_refill_controller_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_in wins.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_in,
  input  logic [IW-1:0] ptr_in,
  output logic [N-1:0]  grant_out,
  output logic [IW-1:0] idx_out,
  output logic          any_out
);

  always_comb begin
    grant_out = '0;
    idx_out   = '0;
    any_out   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr_in) + k) % N;
      if (!any_out && req_in[j]) begin
        any_out      = 1'b1;
        grant_out[j] = 1'b1;
        idx_out      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/l1_refill_controller.sv
// L1 miss handler: round-robin grant, chunk-memory fetch, cache fill and deduplicated acks.
module l1_refill_controller
  import l1_refill_controller_pkg::*;
#(
  parameter int N       = 4,
  parameter int ENTRIES = N,
  localparam int PW = (N > 1) ? $clog2(N) : 1,
  localparam int SW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [N-1:0]      miss_valid_in,
  input  BlockPos [N-1:0]   miss_pos_in,
  output logic [N-1:0]      miss_ack_out,
  output logic              mem_req_out,
  output BlockPos           mem_pos_out,
  input  logic              mem_ready_in,
  input  logic              mem_valid_in,
  input  BlockType          mem_data_in,
  output logic              fill_valid_out,
  output logic [SW-1:0]     fill_slot_out,
  output BlockPos           fill_pos_out,
  output BlockType          fill_block_out,
  output logic              busy_out
);

  function automatic logic in_chunk(BlockPos p);
    return (p.x >= 8'sd0) && (p.x < CHUNK_WIDTH) &&
           (p.y >= 8'sd0) && (p.y < CHUNK_WIDTH) &&
           (p.z >= 8'sd0) && (p.z < CHUNK_WIDTH);
  endfunction

  RefillState    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] victim_q, victim_d;
  BlockPos       pos_q, pos_d;
  BlockType      data_q, data_d;
  logic          mem_req_q, mem_req_d;
  logic          fill_valid_q, fill_valid_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  grant;
  logic [PW-1:0] grant_idx;
  logic          grant_any;
  BlockPos       grant_pos;

  rr_arbiter #(.N(N)) u_arb (
    .req_in    (miss_valid_in),
    .ptr_in    (rr_ptr_q),
    .grant_out (grant),
    .idx_out   (grant_idx),
    .any_out   (grant_any)
  );

  always_comb begin
    grant_pos = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_pos = grant_pos | miss_pos_in[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    victim_d     = victim_q;
    pos_d        = pos_q;
    data_d       = data_q;
    mem_req_d    = 1'b0;
    fill_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          rr_ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
          pos_d    = grant_pos;
          if (!in_chunk(grant_pos)) begin
            // Out-of-chunk blocks are air by definition; no memory traffic.
            data_d       = BLOCK_AIR;
            state_d      = FILL;
            fill_valid_d = 1'b1;
          end else begin
            state_d   = ISSUE;
            mem_req_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (mem_req_q && mem_ready_in) state_d = WAIT;
        else                           mem_req_d = 1'b1;
      end
      WAIT: begin
        if (mem_valid_in) begin
          data_d       = mem_data_in;
          state_d      = FILL;
          fill_valid_d = 1'b1;
        end
      end
      FILL: begin
        victim_d = (victim_q == SW'(ENTRIES - 1)) ? '0 : victim_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      victim_q     <= '0;
      pos_q        <= '0;
      data_q       <= BLOCK_AIR;
      mem_req_q    <= 1'b0;
      fill_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      victim_q     <= victim_d;
      pos_q        <= pos_d;
      data_q       <= data_d;
      mem_req_q    <= mem_req_d;
      fill_valid_q <= fill_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Every requester still waiting on the filled position is released together.
  always_comb begin
    miss_ack_out = '0;
    for (int i = 0; i < N; i++) begin
      miss_ack_out[i] = fill_valid_q && miss_valid_in[i] && (miss_pos_in[i] == pos_q);
    end
  end

  assign mem_req_out    = mem_req_q;
  assign mem_pos_out    = pos_q;
  assign fill_valid_out = fill_valid_q;
  assign fill_slot_out  = victim_q;
  assign fill_pos_out   = pos_q;
  assign fill_block_out = data_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_l1_refill_controller.sv
// Self-checking bench for l1_refill_controller: directed cases plus randomized refills against a transaction-level model.
module tb_l1_refill_controller;
  import l1_refill_controller_pkg::*;

  localparam int N       = 4;
  localparam int ENTRIES = 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [N-1:0]  miss_valid_in;
  BlockPos [N-1:0] miss_pos_in;
  logic [N-1:0]  miss_ack_out;
  logic          mem_req_out;
  BlockPos       mem_pos_out;
  logic          mem_ready_in;
  logic          mem_valid_in;
  BlockType      mem_data_in;
  logic          fill_valid_out;
  logic [1:0]    fill_slot_out;
  BlockPos       fill_pos_out;
  BlockType      fill_block_out;
  logic          busy_out;

  l1_refill_controller #(.N(N), .ENTRIES(ENTRIES)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .miss_valid_in  (miss_valid_in),
    .miss_pos_in    (miss_pos_in),
    .miss_ack_out   (miss_ack_out),
    .mem_req_out    (mem_req_out),
    .mem_pos_out    (mem_pos_out),
    .mem_ready_in   (mem_ready_in),
    .mem_valid_in   (mem_valid_in),
    .mem_data_in    (mem_data_in),
    .fill_valid_out (fill_valid_out),
    .fill_slot_out  (fill_slot_out),
    .fill_pos_out   (fill_pos_out),
    .fill_block_out (fill_block_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  int rr     = 0;
  int victim = 0;
  logic [N-1:0] pend;
  BlockPos      pos_m [N];

  always @(posedge clk_in) begin
    if (rst_n_in && mem_req_out && mem_ready_in) hs_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic bit pos_in_chunk(BlockPos p);
    int cx, cy, cz;
    cx = int'(p.x); cy = int'(p.y); cz = int'(p.z);
    return cx >= 0 && cx < 16 && cy >= 0 && cy < 16 && cz >= 0 && cz < 16;
  endfunction

  task automatic drive_miss();
    miss_valid_in = pend;
    for (int i = 0; i < N; i++) miss_pos_in[i] = pos_m[i];
  endtask

  // One complete refill starting from IDLE with pend non-empty.
  task automatic refill(input int stall, input int lat, input bit abandon);
    int w;
    int hs0;
    BlockPos p;
    BlockType d;
    logic [N-1:0] exp_ack;
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && pend[(rr + k) % N]) w = (rr + k) % N;
    end
    if (w < 0) begin
      check("model_no_pending", 64'(pend), 64'd1);
      return;
    end
    rr  = (w + 1) % N;
    p   = pos_m[w];
    hs0 = hs_cnt;
    mem_ready_in = 1'b0;
    mem_valid_in = 1'($urandom % 2);
    mem_data_in  = 16'($urandom);
    tick();
    check("busy_after_grant", 64'(busy_out), 64'd1);
    if (!pos_in_chunk(p)) begin
      d = BLOCK_AIR;
      check("air_no_req", 64'(mem_req_out), 64'd0);
      mem_valid_in = 1'b0;
    end else begin
      check("req_issue", 64'(mem_req_out), 64'd1);
      check("req_pos", 64'(mem_pos_out), 64'(p));
      check("no_fill_in_issue", 64'(fill_valid_out), 64'd0);
      for (int s = 0; s < stall; s++) begin
        mem_ready_in = 1'b0;
        mem_valid_in = 1'($urandom % 2);
        tick();
        check("req_stall_hold", 64'(mem_req_out), 64'd1);
        check("req_stall_pos", 64'(mem_pos_out), 64'(p));
      end
      mem_ready_in = 1'b1;
      mem_valid_in = 1'($urandom % 2);
      tick();
      check("req_drop_after_hs", 64'(mem_req_out), 64'd0);
      check("no_fill_after_hs", 64'(fill_valid_out), 64'd0);
      if (abandon) begin
        pend[w] = 1'b0;
        drive_miss();
      end
      for (int l = 0; l < lat; l++) begin
        mem_ready_in = 1'($urandom % 2);
        mem_valid_in = 1'b0;
        tick();
        check("no_fill_wait", 64'(fill_valid_out), 64'd0);
        check("busy_wait", 64'(busy_out), 64'd1);
      end
      d = 16'($urandom);
      mem_ready_in = 1'b0;
      mem_valid_in = 1'b1;
      mem_data_in  = d;
      tick();
      mem_valid_in = 1'b0;
    end
    exp_ack = '0;
    for (int i = 0; i < N; i++) exp_ack[i] = pend[i] && (pos_m[i] == p);
    check("fill_valid", 64'(fill_valid_out), 64'd1);
    check("fill_slot", 64'(fill_slot_out), 64'(victim));
    check("fill_pos", 64'(fill_pos_out), 64'(p));
    check("fill_block", 64'(fill_block_out), 64'(d));
    check("ack_mask", 64'(miss_ack_out), 64'(exp_ack));
    check("mem_handshakes", 64'(hs_cnt - hs0), pos_in_chunk(p) ? 64'd1 : 64'd0);
    victim = (victim + 1) % ENTRIES;
    pend   = pend & ~exp_ack;
    drive_miss();
    tick();
    check("fill_one_cycle", 64'(fill_valid_out), 64'd0);
    check("ack_one_cycle", 64'(miss_ack_out), 64'd0);
    check("idle_between", 64'(busy_out), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 64'(mem_req_out), 64'd0);
    check({tag, "_mem_pos"}, 64'(mem_pos_out), 64'd0);
    check({tag, "_fill_valid"}, 64'(fill_valid_out), 64'd0);
    check({tag, "_slot"}, 64'(fill_slot_out), 64'd0);
    check({tag, "_fill_pos"}, 64'(fill_pos_out), 64'd0);
    check({tag, "_block"}, 64'(fill_block_out), 64'(BLOCK_AIR));
    check({tag, "_ack"}, 64'(miss_ack_out), 64'd0);
    check({tag, "_busy"}, 64'(busy_out), 64'd0);
  endtask

  initial begin
    rst_n_in     = 1'b0;
    pend         = '0;
    for (int i = 0; i < N; i++) pos_m[i] = '0;
    drive_miss();
    mem_ready_in = 1'b0;
    mem_valid_in = 1'b0;
    mem_data_in  = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n_in = 1'b1;
    tick();

    // Ports 0 and 3 on distinct positions, then both again.
    pend = 4'b1001;
    pos_m[0] = '{8'sd5, 8'sd5, 8'sd5};
    pos_m[3] = '{8'sd6, 8'sd6, 8'sd6};
    drive_miss();
    refill(0, 1, 1'b0);
    refill(1, 0, 1'b0);
    pend = 4'b1001;
    drive_miss();
    refill(0, 0, 1'b0);
    refill(0, 0, 1'b0);

    // Single miss on port 2.
    pend = 4'b0100;
    pos_m[2] = '{8'sd1, 8'sd2, 8'sd3};
    drive_miss();
    refill(0, 2, 1'b0);

    // Shared position on ports 1 and 2.
    pend = 4'b0110;
    pos_m[1] = '{8'sd4, 8'sd4, 8'sd4};
    pos_m[2] = '{8'sd4, 8'sd4, 8'sd4};
    drive_miss();
    refill(1, 1, 1'b0);

    // Out-of-chunk position.
    pend = 4'b0001;
    pos_m[0] = '{-8'sd1, 8'sd0, 8'sd0};
    drive_miss();
    refill(0, 0, 1'b0);

    // Long stall, then abandoned requester.
    pend = 4'b1000;
    pos_m[3] = '{8'sd2, 8'sd3, 8'sd1};
    drive_miss();
    refill(3, 1, 1'b0);
    pend = 4'b0010;
    pos_m[1] = '{8'sd7, 8'sd0, 8'sd1};
    drive_miss();
    refill(0, 2, 1'b1);

    // Reset in the middle of a memory wait.
    pend = 4'b1000;
    pos_m[3] = '{8'sd2, 8'sd2, 8'sd2};
    drive_miss();
    mem_ready_in = 1'b1;
    tick();
    tick();
    check("wait_busy_before_reset", 64'(busy_out), 64'd1);
    mem_ready_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    check_all_zero("async_reset");
    pend = '0;
    drive_miss();
    rr = 0;
    victim = 0;
    tick();
    rst_n_in = 1'b1;
    mem_valid_in = 1'b1;
    mem_data_in  = 16'h5a5a;
    tick();
    mem_valid_in = 1'b0;
    check("late_resp_no_fill", 64'(fill_valid_out), 64'd0);
    check("late_resp_idle", 64'(busy_out), 64'd0);
    tick();
    check("late_resp_no_fill2", 64'(fill_valid_out), 64'd0);
    pend = 4'b0100;
    pos_m[2] = '{8'sd1, 8'sd2, 8'sd3};
    drive_miss();
    refill(0, 1, 1'b0);

    // Randomized refills with overlapping positions and late joiners.
    for (int r = 0; r < 80; r++) begin
      if (pend == '0 || ($urandom % 3) == 0) begin
        logic [N-1:0] add;
        add = 4'($urandom);
        for (int i = 0; i < N; i++) begin
          if (add[i] && !pend[i]) begin
            pend[i]    = 1'b1;
            pos_m[i].x = (($urandom % 8) == 0) ? -8'sd1 : 8'($urandom % 3);
            pos_m[i].y = 8'($urandom % 2);
            pos_m[i].z = (($urandom % 12) == 0) ? 8'sd16 : 8'($urandom % 2);
          end
        end
        if (pend == '0) begin
          pend[0]  = 1'b1;
          pos_m[0] = '{8'sd0, 8'sd1, 8'sd0};
        end
      end
      drive_miss();
      refill(int'($urandom % 4), int'($urandom % 4), (($urandom % 6) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
